// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word-aligned memory requests and
// presents returned words to the decoder through a one-entry output register.
//
// state      | meaning
// FETCH_IDLE | first cycle after reset, no request
// FETCH_REQ  | request at pc offered while the output register can take a word
// FETCH_WAIT | one request in flight, its word will be loaded
// FETCH_DROP | one request in flight that a redirect has orphaned
module fetch_unit #(
  parameter int              XLEN     = fetch_unit_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_unit_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  import fetch_unit_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            inst_valid_q, inst_valid_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            req_fire;
  logic [XLEN-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_valid_d   = inst_valid_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    imem_req_valid = 1'b0;

    // Only request when the output register is guaranteed empty by the time
    // the word returns, so a response never has to be stalled.
    if (state_q == FETCH_REQ) begin
      imem_req_valid = !inst_valid_q || inst_ready;
    end
    req_fire = imem_req_valid && imem_req_ready;

    if (inst_valid_q && inst_ready) begin
      inst_valid_d = 1'b0;
    end

    unique case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (req_fire) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          inst_valid_d = 1'b1;
          inst_d       = imem_resp_data;
          inst_pc_d    = pc_q;
          pc_d         = pc_q + XLEN'(4);
          state_d      = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        if (imem_resp_valid) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_IDLE;
    endcase

    // Redirect overrides everything above: flush, reload pc, and make sure the
    // word of any request already accepted is thrown away.
    if (redirect_valid) begin
      inst_valid_d = 1'b0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      pc_d         = redirect_pc_aligned;
      unique case (state_q)
        FETCH_IDLE: state_d = FETCH_REQ;
        FETCH_REQ:  state_d = req_fire ? FETCH_DROP : FETCH_REQ;
        FETCH_WAIT,
        FETCH_DROP: state_d = imem_resp_valid ? FETCH_REQ : FETCH_DROP;
        default:    state_d = FETCH_IDLE;
      endcase
    end
  end

  assign imem_req_addr = pc_q;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;

endmodule
